// File: rtl/fccc_lock_ce_gen_if.sv
// rtl/fccc_lock_ce_gen_if.sv - lock supervisor / clock-enable generator signal bundle
interface fccc_lock_ce_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    logic                    lock;
    logic [NUM_CH*DIV_W-1:0] div_cfg;
    logic [NUM_CH-1:0]       ch_en;
    logic                    clr_lost;
    logic [NUM_CH-1:0]       ce_out;
    logic                    lock_ok;
    logic                    lock_lost;
    logic                    rst_out_n;

    modport master (
        output lock, div_cfg, ch_en, clr_lost,
        input  ce_out, lock_ok, lock_lost, rst_out_n
    );

    modport slave (
        input  lock, div_cfg, ch_en, clr_lost,
        output ce_out, lock_ok, lock_lost, rst_out_n
    );
endinterface

// File: rtl/fccc_lock_ce_gen.sv
// rtl/fccc_lock_ce_gen.sv - CCC lock qualifier, downstream reset release and clock-enable generator
module fccc_lock_ce_gen #(
    parameter int NUM_CH             = 4,
    parameter int DIV_W              = 8,
    parameter int LOCK_SYNC_STAGES   = 2,
    parameter int LOCK_STABLE_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fccc_lock_ce_gen_if.slave       bus
);

    localparam int CNT_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                      state, state_next;
    logic   [CNT_W-1:0]          stable_cnt, stable_cnt_next;
    logic   [LOCK_SYNC_STAGES-1:0] lock_sync;
    logic                        lock_s;
    logic                        set_lost;
    logic                        lock_lost_q;
    logic                        rst_out_q;
    logic                        run_next;
    logic   [NUM_CH-1:0]         ce_vec;

    // Bring the asynchronous CCC lock flag into the fabric clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[LOCK_SYNC_STAGES-2:0], bus.lock};
        end
    end

    assign lock_s = lock_sync[LOCK_SYNC_STAGES-1];

    // Qualification state and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
        end else begin
            state      <= state_next;
            stable_cnt <= stable_cnt_next;
        end
    end

    // Lock must stay high for the whole window; any drop restarts from zero
    always_comb begin
        state_next      = state;
        stable_cnt_next = stable_cnt;
        set_lost        = 1'b0;
        case (state)
            WAIT_LOCK: begin
                stable_cnt_next = '0;
                if (lock_s) begin
                    state_next = STABLE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next      = WAIT_LOCK;
                    stable_cnt_next = '0;
                end else if (stable_cnt == CNT_LAST) begin
                    state_next = RUN;
                end else begin
                    stable_cnt_next = stable_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                stable_cnt_next = '0;
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    set_lost   = 1'b1;
                end
            end
            default: begin
                state_next      = WAIT_LOCK;
                stable_cnt_next = '0;
            end
        endcase
    end

    // Sticky loss flag; a new loss beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost_q <= 1'b0;
        end else if (set_lost) begin
            lock_lost_q <= 1'b1;
        end else if (bus.clr_lost) begin
            lock_lost_q <= 1'b0;
        end
    end

    // Downstream reset follows LOCK_OK one cycle late in both directions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_out_q <= 1'b0;
        end else begin
            rst_out_q <= (state == RUN);
        end
    end

    // Channels look at the next state so that entry to and exit from RUN act on
    // the same edge as LOCK_OK changes
    assign run_next = (state_next == RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_i;
        logic [DIV_W-1:0] div_cnt;
        logic [DIV_W-1:0] shadow;
        logic             act;
        logic             act_q;
        logic             ce_q;

        assign div_i = bus.div_cfg[i*DIV_W +: DIV_W];
        assign act   = run_next & bus.ch_en[i];

        // Divider: load on activation, reload the divisor only at wrap
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                div_cnt <= '0;
                shadow  <= '0;
                act_q   <= 1'b0;
                ce_q    <= 1'b0;
            end else if (!act) begin
                div_cnt <= '0;
                act_q   <= 1'b0;
                ce_q    <= 1'b0;
            end else if (!act_q) begin
                div_cnt <= '0;
                shadow  <= div_i;
                act_q   <= 1'b1;
                ce_q    <= 1'b0;
            end else if (div_cnt == shadow) begin
                div_cnt <= '0;
                shadow  <= div_i;
                ce_q    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
                ce_q    <= 1'b0;
            end
        end

        assign ce_vec[i] = ce_q;
    end

    assign bus.ce_out    = ce_vec;
    assign bus.lock_ok   = (state == RUN);
    assign bus.lock_lost = lock_lost_q;
    assign bus.rst_out_n = rst_out_q;

endmodule

// File: tb/tb_fccc_lock_ce_gen.sv
// tb/tb_fccc_lock_ce_gen.sv - directed scoreboard bench for fccc_lock_ce_gen
module tb_fccc_lock_ce_gen;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    typedef struct {
        string      tag;
        logic [3:0] ce;
        logic       ok;
        logic       lost;
        logic       rstn;
    } exp_t;

    exp_t sb[$];

    fccc_lock_ce_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    fccc_lock_ce_gen #(
        .NUM_CH            (NUM_CH),
        .DIV_W             (DIV_W),
        .LOCK_SYNC_STAGES  (2),
        .LOCK_STABLE_CYCLES(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] ce, input logic ok,
                        input logic lost, input logic rstn);
        exp_t e;
        e.tag  = tag;
        e.ce   = ce;
        e.ok   = ok;
        e.lost = lost;
        e.rstn = rstn;
        sb.push_back(e);
    endtask

    task automatic tick_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s_ce", e.tag),   32'(bus.ce_out),    32'(e.ce));
            chk($sformatf("%s_ok", e.tag),   32'(bus.lock_ok),   32'(e.ok));
            chk($sformatf("%s_lost", e.tag), 32'(bus.lock_lost), 32'(e.lost));
            chk($sformatf("%s_rstn", e.tag), 32'(bus.rst_out_n), 32'(e.rstn));
        end
    endtask

    task automatic wait_lock_ok(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.lock_ok && n < 60);
    endtask

    initial begin
        int   n;
        logic c0;
        logic c1;

        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.lock     = 1'b1;
        bus.div_cfg  = '0;
        bus.ch_en    = '0;
        bus.clr_lost = 1'b0;

        // reset values while LOCK is already high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce",   32'(bus.ce_out),    32'h0);
        chk("rst_ok",   32'(bus.lock_ok),   32'h0);
        chk("rst_lost", 32'(bus.lock_lost), 32'h0);
        chk("rst_rstn", 32'(bus.rst_out_n), 32'h0);

        // lock held from cycle 0: LOCK_OK at edge 19, RST_OUT_N at edge 20
        rst_n = 1'b1;
        wait_lock_ok(n);
        chk("lock_latency", 32'(n), 32'd19);
        chk("lock_rstn_e19", 32'(bus.rst_out_n), 32'h0);
        chk("lock_lost_e19", 32'(bus.lock_lost), 32'h0);
        @(posedge clk);
        #1;
        chk("lock_rstn_e20", 32'(bus.rst_out_n), 32'h1);

        // ch0 d=3, ch1 d=0; ch0 changes to 1 mid-period; lock drops after k=24
        bus.div_cfg = 32'h0000_0003;
        bus.ch_en   = 4'b0011;
        for (int k = 1; k <= 28; k++) begin
            if (k <= 26) begin
                c0 = (k == 5) || (k == 9) || (k == 13) || (k > 13 && ((k - 13) % 2 == 0));
                c1 = (k >= 2);
                push($sformatf("run_k%0d", k), {2'b00, c1, c0}, 1'b1, 1'b0, 1'b1);
            end else if (k == 27) begin
                push("loss_k27", 4'b0000, 1'b0, 1'b1, 1'b1);
            end else begin
                push("loss_k28", 4'b0000, 1'b0, 1'b1, 1'b0);
            end
        end
        for (int k = 1; k <= 28; k++) begin
            tick_check();
            if (k == 10) bus.div_cfg = 32'h0000_0001;
            if (k == 24) bus.lock = 1'b0;
        end

        // a lone clear pulse drops the sticky flag
        bus.clr_lost = 1'b1;
        push("clr", 4'b0000, 1'b0, 1'b0, 1'b0);
        tick_check();
        bus.clr_lost = 1'b0;

        // 10 cycles high, one low, then high: qualification restarts
        bus.lock = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.lock = 1'b0;
        @(posedge clk);
        #1;
        bus.lock = 1'b1;
        wait_lock_ok(n);
        chk("glitch_latency", 32'(n), 32'd19);
        chk("relock_ce_entry", 32'(bus.ce_out), 32'h0);

        // channels activate on entry to RUN with ch0 d=1, ch1 d=0
        push("relock_1", 4'b0010, 1'b1, 1'b0, 1'b1);
        push("relock_2", 4'b0011, 1'b1, 1'b0, 1'b1);
        push("relock_3", 4'b0010, 1'b1, 1'b0, 1'b1);
        push("relock_4", 4'b0011, 1'b1, 1'b0, 1'b1);
        repeat (4) tick_check();

        // second loss with clear coincident on the RUN exit edge
        bus.lock = 1'b0;
        push("loss2_1", 4'b0010, 1'b1, 1'b0, 1'b1);
        push("loss2_2", 4'b0011, 1'b1, 1'b0, 1'b1);
        push("loss2_3", 4'b0000, 1'b0, 1'b1, 1'b1);
        push("loss2_4", 4'b0000, 1'b0, 1'b1, 1'b0);
        tick_check();
        tick_check();
        bus.clr_lost = 1'b1;
        tick_check();
        bus.clr_lost = 1'b0;
        tick_check();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        // async reset in the middle of RUN
        bus.lock = 1'b1;
        wait_lock_ok(n);
        chk("relock2_latency", 32'(n), 32'd19);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_arst_ce1", 32'(bus.ce_out[1]), 32'h1);
        chk("pre_arst_lost", 32'(bus.lock_lost), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ce",   32'(bus.ce_out),    32'h0);
        chk("arst_ok",   32'(bus.lock_ok),   32'h0);
        chk("arst_lost", 32'(bus.lock_lost), 32'h0);
        chk("arst_rstn", 32'(bus.rst_out_n), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
